alu_share_arb: RTL and testbench

Shares one `alu64` datapath between `N_REQ` requesters (e.g. the integer issue port, address generation, and branch compare) using round-robin arbitration. Each requester uses a valid/ready request channel and a valid/ready response channel. The block accepts at most one operation per cycle. It registers the ALU result in a single output slot and returns it, with a tag, to the requester that issued it. It sits between the issue logic and the shared ALU instance.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu64.sv | 28 ++
 rtl/alu_share_arb.sv | 110 +++++++++++
 tb/tb_alu_share_arb.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Op codes and slot state shared by the ALU arbiter and the ALU datapath.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [3:0] ALU_OP_MAX = 4'd9;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/alu64.sv
// Combinational 64-bit integer ALU; undefined op codes yield zero.
module alu64
    import alu_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [3:0]  op,
    output logic [63:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << b[5:0];
            ALU_SRL:  result = a >> b[5:0];
            ALU_SRA:  result = $signed(a) >>> b[5:0];
            ALU_SLT:  result = {63'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {63'b0, a < b};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one alu64 among N_REQ requesters, with a single
// registered result slot returned to the issuing requester.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][63:0]      req_a,
    input  logic [N_REQ-1:0][63:0]      req_b,
    input  logic [N_REQ-1:0][3:0]       req_op,
    input  logic [N_REQ-1:0][TAG_W-1:0] req_tag,
    output logic [N_REQ-1:0]            rsp_valid,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [63:0]                 rsp_result,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic                        rsp_illegal
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    // First valid index scanning cyclically upward from ptr.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && valid[idx[IDX_W-1:0]]) begin
                pick  = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    slot_state_t       slot_q;
    logic [IDX_W-1:0]  owner_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [63:0]       result_q;
    logic [TAG_W-1:0]  tag_q;
    logic              illegal_q;

    logic [IDX_W-1:0]  winner;
    logic              slot_free;
    logic              grant;
    logic [63:0]       sel_a;
    logic [63:0]       sel_b;
    logic [3:0]        sel_op;
    logic [63:0]       alu_result;

    assign winner    = rr_pick(req_valid, rr_ptr_q);
    assign slot_free = (slot_q == EMPTY) || rsp_ready[owner_q];
    // Gated by rst so no request is acknowledged while reset is held.
    assign grant     = (|req_valid) && slot_free && !rst;

    assign sel_a  = req_a[winner];
    assign sel_b  = req_b[winner];
    assign sel_op = req_op[winner];

    alu64 u_alu (
        .a      (sel_a),
        .b      (sel_b),
        .op     (sel_op),
        .result (alu_result)
    );

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (slot_q == FULL) rsp_valid[owner_q] = 1'b1;
    end

    assign rsp_result  = result_q;
    assign rsp_tag     = tag_q;
    assign rsp_illegal = illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q    <= EMPTY;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            result_q  <= '0;
            tag_q     <= '0;
            illegal_q <= 1'b0;
        end else if (grant) begin
            slot_q    <= FULL;
            owner_q   <= winner;
            result_q  <= alu_result;
            tag_q     <= req_tag[winner];
            illegal_q <= (sel_op > ALU_OP_MAX);
            rr_ptr_q  <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
        end else if (slot_q == FULL && rsp_ready[owner_q]) begin
            slot_q <= EMPTY;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed-vector bench for alu_share_arb with two requesters.
module tb_alu_share_arb;
    import alu_pkg::*;

    localparam int unsigned N_REQ = 2;
    localparam int unsigned TAG_W = 4;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic [3:0]  tag;
    } vec_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0][63:0]      req_a;
    logic [N_REQ-1:0][63:0]      req_b;
    logic [N_REQ-1:0][3:0]       req_op;
    logic [N_REQ-1:0][TAG_W-1:0] req_tag;
    logic [N_REQ-1:0]            rsp_valid;
    logic [N_REQ-1:0]            rsp_ready;
    logic [63:0]                 rsp_result;
    logic [TAG_W-1:0]            rsp_tag;
    logic                        rsp_illegal;

    int n_vec = 0;
    int n_err = 0;

    vec_t v0[4];
    vec_t v1[4];
    vec_t vs;
    vec_t ve;

    alu_share_arb #(
        .N_REQ (N_REQ),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .req_tag     (req_tag),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_tag     (rsp_tag),
        .rsp_illegal (rsp_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input vec_t v);
        req_op[r]  = v.op;
        req_a[r]   = v.a;
        req_b[r]   = v.b;
        req_tag[r] = v.tag;
    endtask

    initial begin
        v0[0] = '{ALU_SRA, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1};
        v0[1] = '{ALU_SUB, 64'd10, 64'd3, 64'd7, 4'd2};
        v0[2] = '{ALU_XOR, 64'hF0F0, 64'h0FF0, 64'hFF00, 4'd3};
        v0[3] = '{ALU_AND, 64'hFF, 64'h0F, 64'h0F, 4'd4};
        v1[0] = '{ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 4'd8};
        v1[1] = '{ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'd9};
        v1[2] = '{ALU_SLL, 64'd1, 64'h44, 64'h10, 4'd10};
        v1[3] = '{ALU_OR, 64'hA0, 64'h05, 64'hA5, 4'd11};

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_tag   = '0;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_result", rsp_result, 64'd0);
        check("rst_tag", 64'(rsp_tag), 64'd0);
        check("rst_illegal", 64'(rsp_illegal), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle", 64'({rsp_valid, req_ready}), 64'd0);
        end

        // Single ADD from requester 1.
        rsp_ready = 2'b11;
        vs = '{ALU_ADD, 64'd5, 64'd7, 64'd12, 4'd3};
        set_req(1, vs);
        req_valid = 2'b10;
        #1 check("single_grant", 64'(req_ready), 64'b10);
        tick();
        req_valid = '0;
        #1;
        check("single_valid", 64'(rsp_valid), 64'b10);
        check("single_result", rsp_result, 64'd12);
        check("single_tag", 64'(rsp_tag), 64'd3);
        check("single_illegal", 64'(rsp_illegal), 64'd0);
        tick();
        check("single_drain", 64'(rsp_valid), 64'd0);

        // Both requesters valid: grants alternate starting at 0.
        for (int k = 0; k < 6; k++) begin
            set_req(0, v0[(k + 1) / 2]);
            set_req(1, v1[k / 2]);
            req_valid = 2'b11;
            #1 check("rr_grant", 64'(req_ready), 64'(1) << (k % 2));
            tick();
            #1;
            ve = (k % 2 == 0) ? v0[k / 2] : v1[k / 2];
            check("rr_valid", 64'(rsp_valid), 64'(1) << (k % 2));
            check("rr_result", rsp_result, ve.exp);
            check("rr_tag", 64'(rsp_tag), 64'(ve.tag));
        end

        // Owner 1 stalls; non-owner rsp_ready must not free the slot.
        set_req(1, v1[3]);
        rsp_ready = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1 check("bp_ready", 64'(req_ready), 64'd0);
            tick();
            check("bp_valid", 64'(rsp_valid), 64'b10);
            check("bp_result", rsp_result, 64'h10);
            check("bp_tag", 64'(rsp_tag), 64'd10);
        end
        rsp_ready = 2'b11;
        #1 check("bp_release_grant", 64'(req_ready), 64'b01);
        tick();
        check("bp_release_valid", 64'(rsp_valid), 64'b01);
        check("bp_release_result", rsp_result, 64'h0F);
        check("bp_release_tag", 64'(rsp_tag), 64'd4);
        req_valid = 2'b10;
        #1 check("bp_next_grant", 64'(req_ready), 64'b10);
        tick();
        check("bp_next_valid", 64'(rsp_valid), 64'b10);
        check("bp_next_result", rsp_result, 64'hA5);
        check("bp_next_tag", 64'(rsp_tag), 64'd11);
        req_valid = '0;
        tick();
        check("bp_empty", 64'(rsp_valid), 64'd0);

        // Illegal op 12.
        vs = '{4'd12, 64'hFF, 64'hFF, 64'd0, 4'd5};
        set_req(0, vs);
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        #1 check("ill_grant", 64'(req_ready), 64'b01);
        tick();
        req_valid = '0;
        #1;
        check("ill_valid", 64'(rsp_valid), 64'b01);
        check("ill_result", rsp_result, 64'd0);
        check("ill_flag", 64'(rsp_illegal), 64'd1);
        check("ill_tag", 64'(rsp_tag), 64'd5);

        // Reset while FULL, mid-cycle; pointer was 1 before reset.
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(rsp_valid), 64'd0);
        check("arst_result", rsp_result, 64'd0);
        check("arst_illegal", 64'(rsp_illegal), 64'd0);
        check("arst_tag", 64'(rsp_tag), 64'd0);
        set_req(0, v0[0]);
        set_req(1, v1[3]);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1 check("arst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_grant", 64'(req_ready), 64'b01);
        tick();
        check("post_rst_valid", 64'(rsp_valid), 64'b01);
        check("post_rst_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("post_rst_tag", 64'(rsp_tag), 64'd1);
        req_valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
